// File: rtl/xbar_pkg.sv
// Shared opcode encodings and lane-action field layout for the operand crossbar.
// Latency: n/a (constants only).
// Backpressure: n/a.
package xbar_pkg;

    // Two-register-operand ALU ops
    localparam logic [3:0] OP_ADD    = 4'b0001;
    localparam logic [3:0] OP_SUB    = 4'b0010;
    localparam logic [3:0] OP_ADD_X  = 4'b1001;
    localparam logic [3:0] OP_SUB_X  = 4'b1010;
    // Register + immediate ALU ops
    localparam logic [3:0] OP_ADDI   = 4'b0011;
    localparam logic [3:0] OP_SUBI   = 4'b0100;
    localparam logic [3:0] OP_ADDI_X = 4'b1011;
    localparam logic [3:0] OP_SUBI_X = 4'b1100;
    // Pass-through: lane forwards its own container
    localparam logic [3:0] OP_NOP    = 4'b0000;

    // Lane action layout; op2 index and immediate share the low bits
    localparam int OPC_LSB = 21;
    localparam int OPC_W   = 4;
    localparam int OP1_LSB = 16;
    localparam int OP2_LSB = 11;
    localparam int IDX_W   = 5;
    localparam int IMM_LSB = 0;
    localparam int IMM_W   = 16;

endpackage

// File: rtl/phv_fifo.sv
// PHV holding FIFO: buffers whole PHVs until their action arrives.
// Latency: head visible the cycle after push into an empty FIFO (rdata is combinational off the head).
// Backpressure: full_o from registered count; a push while full is ignored even if popping.
module phv_fifo #(
    parameter int WIDTH = 384,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];

    // Next pointers and occupancy
    always_comb begin
        wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!do_push && do_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    // Pointer/count state; reset empties the FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: only entries covered by count are ever read
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/action_operand_xbar.sv
// Pairs buffered PHVs with VLIW actions and muxes per-lane ALU operands; PHV delayed to meet ALU results.
// Latency: ALU action/operands 1 cycle after pairing; aligned PHV 1+ALU_LATENCY cycles after pairing.
// Backpressure: phv_in_ready low while the PHV FIFO is full; actions cannot be stalled (orphans are dropped).
module action_operand_xbar
    import xbar_pkg::*;
#(
    parameter int STAGE          = 0,
    parameter int ACTION_LEN     = 25,
    parameter int DATA_WIDTH     = 48,
    parameter int NUM_ALU        = 8,
    parameter int PHV_FIFO_DEPTH = 4,
    parameter int ALU_LATENCY    = 3
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_ALU*DATA_WIDTH-1:0]    phv_in,
    input  logic                             phv_in_valid,
    output logic                             phv_in_ready,
    input  logic [NUM_ALU*ACTION_LEN-1:0]    action_in,
    input  logic                             action_in_valid,
    output logic [NUM_ALU*ACTION_LEN-1:0]    alu_action_out,
    output logic [NUM_ALU-1:0]               alu_action_valid,
    output logic [NUM_ALU*DATA_WIDTH-1:0]    alu_operand_1,
    output logic [NUM_ALU*DATA_WIDTH-1:0]    alu_operand_2,
    output logic [NUM_ALU*DATA_WIDTH-1:0]    phv_aligned_out,
    output logic                             phv_aligned_valid,
    output logic                             err_orphan_action
);

    localparam int PHV_W = NUM_ALU * DATA_WIDTH;
    localparam int ACT_W = NUM_ALU * ACTION_LEN;

    if (STAGE < 0 || PHV_FIFO_DEPTH < 1 || ALU_LATENCY < 0) begin : g_param_check
        $error("action_operand_xbar: illegal parameterisation");
    end

    logic             fifo_full, fifo_empty, fifo_push;
    logic [PHV_W-1:0] fifo_head;
    logic             pair_fifo, bypass, orphan, pair;
    logic [PHV_W-1:0] pair_phv;
    logic [PHV_W-1:0] op1_d, op2_d;

    logic [ACT_W-1:0]   alu_action_q;
    logic [NUM_ALU-1:0] alu_valid_q;
    logic [PHV_W-1:0]   op1_q, op2_q;
    logic [ALU_LATENCY:0]            dly_vld_q;
    logic [ALU_LATENCY:0][PHV_W-1:0] dly_dat_q;
    logic               err_q;

    assign phv_in_ready = !fifo_full;

    // Pairing decision: FIFO head first, then same-cycle bypass, otherwise the action is orphaned
    always_comb begin
        pair_fifo = action_in_valid && !fifo_empty;
        bypass    = action_in_valid && fifo_empty && phv_in_valid;
        orphan    = action_in_valid && fifo_empty && !phv_in_valid;
        pair      = pair_fifo || bypass;
        pair_phv  = '0;
        if (pair_fifo) begin
            pair_phv = fifo_head;
        end else if (bypass) begin
            pair_phv = phv_in;
        end
        fifo_push = phv_in_valid && phv_in_ready && !bypass;
    end

    phv_fifo #(
        .WIDTH (PHV_W),
        .DEPTH (PHV_FIFO_DEPTH)
    ) u_phv_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (fifo_push),
        .wdata_i (phv_in),
        .pop_i   (pair_fifo),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Container select; out-of-range indices read as zero
    function automatic logic [DATA_WIDTH-1:0] pick(input logic [PHV_W-1:0] phv,
                                                    input logic [IDX_W-1:0] idx);
        logic [DATA_WIDTH-1:0] r;
        r = '0;
        for (int k = 0; k < NUM_ALU; k++) begin
            if (int'(idx) == k) begin
                r = phv[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        return r;
    endfunction

    for (genvar g = 0; g < NUM_ALU; g++) begin : g_lane
        logic [ACTION_LEN-1:0] lane_act;
        logic [OPC_W-1:0]      opc;
        logic [IDX_W-1:0]      idx1, idx2;
        logic [IMM_W-1:0]      imm;
        logic [DATA_WIDTH-1:0] lane_op1, lane_op2;

        assign lane_act = action_in[g*ACTION_LEN +: ACTION_LEN];
        assign opc      = lane_act[OPC_LSB +: OPC_W];
        assign idx1     = lane_act[OP1_LSB +: IDX_W];
        assign idx2     = lane_act[OP2_LSB +: IDX_W];
        assign imm      = lane_act[IMM_LSB +: IMM_W];

        // Per-lane operand decode; everything reads zero when no pairing happens
        always_comb begin
            lane_op1 = '0;
            lane_op2 = '0;
            if (pair) begin
                case (opc)
                    OP_ADD, OP_SUB, OP_ADD_X, OP_SUB_X: begin
                        lane_op1 = pick(pair_phv, idx1);
                        lane_op2 = pick(pair_phv, idx2);
                    end
                    OP_ADDI, OP_SUBI, OP_ADDI_X, OP_SUBI_X: begin
                        lane_op1 = pick(pair_phv, idx1);
                        lane_op2 = {{(DATA_WIDTH-IMM_W){1'b0}}, imm};
                    end
                    OP_NOP: begin
                        lane_op1 = pair_phv[g*DATA_WIDTH +: DATA_WIDTH];
                    end
                    default: begin
                    end
                endcase
            end
        end

        assign op1_d[g*DATA_WIDTH +: DATA_WIDTH] = lane_op1;
        assign op2_d[g*DATA_WIDTH +: DATA_WIDTH] = lane_op2;
    end

    // ALU-facing output register: one-cycle pulse per pairing, zero otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_action_q <= '0;
            alu_valid_q  <= '0;
            op1_q        <= '0;
            op2_q        <= '0;
        end else begin
            alu_action_q <= pair ? action_in : '0;
            alu_valid_q  <= {NUM_ALU{pair}};
            op1_q        <= op1_d;
            op2_q        <= op2_d;
        end
    end

    // PHV delay line: stage 0 lines up with the ALU inputs, last stage with ALU results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dly_vld_q <= '0;
            dly_dat_q <= '0;
        end else begin
            dly_vld_q[0] <= pair;
            dly_dat_q[0] <= pair_phv;
            for (int k = 1; k <= ALU_LATENCY; k++) begin
                dly_vld_q[k] <= dly_vld_q[k-1];
                dly_dat_q[k] <= dly_dat_q[k-1];
            end
        end
    end

    // Sticky orphan flag, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (orphan) begin
            err_q <= 1'b1;
        end
    end

    assign alu_action_out    = alu_action_q;
    assign alu_action_valid  = alu_valid_q;
    assign alu_operand_1     = op1_q;
    assign alu_operand_2     = op2_q;
    assign phv_aligned_valid = dly_vld_q[ALU_LATENCY];
    assign phv_aligned_out   = dly_dat_q[ALU_LATENCY];
    assign err_orphan_action = err_q;

endmodule

// File: tb/tb_action_operand_xbar.sv
// Self-checking bench for action_operand_xbar: decode table plus FIFO, orphan and reset sequences.
// Latency: expects ALU outputs 1 cycle and aligned PHV 4 cycles after the pairing edge.
// Backpressure: models the 4-deep PHV FIFO to predict phv_in_ready and pairing order.
module tb_action_operand_xbar;

    localparam int NA    = 8;
    localparam int DW    = 48;
    localparam int AL    = 25;
    localparam int DEPTH = 4;
    localparam int LAT   = 3;
    localparam int PW    = NA * DW;
    localparam int AW    = NA * AL;

    typedef logic [383:0] w_t;

    typedef struct {
        int            cyc;
        logic [AW-1:0] act;
        logic [PW-1:0] o1;
        logic [PW-1:0] o2;
    } alu_exp_t;

    typedef struct {
        int            cyc;
        logic [PW-1:0] phv;
    } phv_exp_t;

    typedef struct {
        int            lane;
        logic [AL-1:0] la;
        logic [DW-1:0] e1;
        logic [DW-1:0] e2;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [PW-1:0] phv_in = '0;
    logic          phv_in_valid = 1'b0;
    logic          phv_in_ready;
    logic [AW-1:0] action_in = '0;
    logic          action_in_valid = 1'b0;
    logic [AW-1:0] alu_action_out;
    logic [NA-1:0] alu_action_valid;
    logic [PW-1:0] alu_operand_1, alu_operand_2, phv_aligned_out;
    logic          phv_aligned_valid;
    logic          err_orphan_action;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    logic [PW-1:0] mq[$];
    alu_exp_t      alu_sb[$];
    phv_exp_t      phv_sb[$];
    logic          err_m = 1'b0;
    vec_t          tbl[8];

    action_operand_xbar dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .phv_in            (phv_in),
        .phv_in_valid      (phv_in_valid),
        .phv_in_ready      (phv_in_ready),
        .action_in         (action_in),
        .action_in_valid   (action_in_valid),
        .alu_action_out    (alu_action_out),
        .alu_action_valid  (alu_action_valid),
        .alu_operand_1     (alu_operand_1),
        .alu_operand_2     (alu_operand_2),
        .phv_aligned_out   (phv_aligned_out),
        .phv_aligned_valid (phv_aligned_valid),
        .err_orphan_action (err_orphan_action)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input w_t a, input w_t e);
        checks++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endtask

    function automatic logic [DW-1:0] cont(input logic [PW-1:0] p, input logic [4:0] ix);
        if (int'(ix) < NA) return p[int'(ix)*DW +: DW];
        return '0;
    endfunction

    // Reference lane decode straight from the opcode table
    function automatic logic [2*DW-1:0] model_lane(input logic [PW-1:0] p, input logic [AL-1:0] la, input int i);
        logic [3:0] opc;
        opc = la[24:21];
        case (opc)
            4'b0001, 4'b0010, 4'b1001, 4'b1010: return {cont(p, la[20:16]), cont(p, la[15:11])};
            4'b0011, 4'b0100, 4'b1011, 4'b1100: return {cont(p, la[20:16]), 32'h0, la[15:0]};
            4'b0000: return {p[i*DW +: DW], 48'h0};
            default: return '0;
        endcase
    endfunction

    function automatic logic [AW-1:0] mk_act(input int lane, input logic [AL-1:0] la);
        logic [AW-1:0] a;
        a = '0;
        a[lane*AL +: AL] = la;
        return a;
    endfunction

    function automatic logic [PW-1:0] mkphv(input int k);
        logic [PW-1:0] p;
        for (int j = 0; j < NA; j++) p[j*DW +: DW] = DW'(k * 256 + j);
        return p;
    endfunction

    // One cycle of stimulus; inputs sampled at the next posedge. tl>=0 pins lane tl to table values.
    task automatic drive(input logic pv, input logic [PW-1:0] p, input logic av, input logic [AW-1:0] a,
                         input int tl, input logic [DW-1:0] e1, input logic [DW-1:0] e2);
        logic          rdy, paired, byp;
        logic [PW-1:0] pp;
        alu_exp_t      ae;
        phv_exp_t      pe;
        logic [2*DW-1:0] lo;
        rdy = (mq.size() < DEPTH);
        chk("phv_in_ready", w_t'(phv_in_ready), w_t'(rdy));
        chk("err_orphan", w_t'(err_orphan_action), w_t'(err_m));
        paired = 1'b0; byp = 1'b0; pp = '0;
        if (av) begin
            if (mq.size() > 0) begin
                pp = mq.pop_front(); paired = 1'b1;
            end else if (pv) begin
                pp = p; paired = 1'b1; byp = 1'b1;
            end else begin
                err_m = 1'b1;
            end
        end
        if (pv && rdy && !byp) mq.push_back(p);
        if (paired) begin
            ae.cyc = cyc + 1; ae.act = a;
            for (int i = 0; i < NA; i++) begin
                lo = model_lane(pp, a[i*AL +: AL], i);
                ae.o1[i*DW +: DW] = lo[2*DW-1:DW];
                ae.o2[i*DW +: DW] = lo[DW-1:0];
            end
            if (tl >= 0) begin
                ae.o1[tl*DW +: DW] = e1;
                ae.o2[tl*DW +: DW] = e2;
            end
            alu_sb.push_back(ae);
            pe.cyc = cyc + 1 + LAT; pe.phv = pp;
            phv_sb.push_back(pe);
        end
        phv_in = p; phv_in_valid = pv; action_in = a; action_in_valid = av;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, '0, -1, '0, '0);
    endtask

    // Scoreboard monitor, sampling 2 ns after each rising edge
    initial begin
        alu_exp_t ae;
        phv_exp_t pe;
        forever begin
            @(posedge clk); #2;
            if (alu_action_valid != '0) begin
                if (alu_sb.size() == 0) begin
                    chk("alu_unexpected", w_t'(alu_action_valid), w_t'(0));
                end else begin
                    ae = alu_sb.pop_front();
                    chk("alu_cycle", w_t'(cyc), w_t'(ae.cyc));
                    chk("alu_valid", w_t'(alu_action_valid), w_t'(8'hFF));
                    chk("alu_action", w_t'(alu_action_out), w_t'(ae.act));
                    chk("alu_op1", alu_operand_1, ae.o1);
                    chk("alu_op2", alu_operand_2, ae.o2);
                end
            end else begin
                chk("alu_idle_zero", w_t'(alu_action_out) | alu_operand_1 | alu_operand_2, w_t'(0));
            end
            if (phv_aligned_valid) begin
                if (phv_sb.size() == 0) begin
                    chk("phv_unexpected", w_t'(phv_aligned_valid), w_t'(0));
                end else begin
                    pe = phv_sb.pop_front();
                    chk("phv_cycle", w_t'(cyc), w_t'(pe.cyc));
                    chk("phv_data", phv_aligned_out, pe.phv);
                end
            end else begin
                chk("phv_idle_zero", phv_aligned_out, w_t'(0));
            end
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_alu_vld"}, w_t'(alu_action_valid), w_t'(0));
        chk({tag, "_alu_act"}, w_t'(alu_action_out), w_t'(0));
        chk({tag, "_ops"}, alu_operand_1 | alu_operand_2, w_t'(0));
        chk({tag, "_phv"}, w_t'(phv_aligned_valid) | phv_aligned_out, w_t'(0));
        chk({tag, "_err"}, w_t'(err_orphan_action), w_t'(0));
        chk({tag, "_ready"}, w_t'(phv_in_ready), w_t'(1));
    endtask

    initial begin
        logic [PW-1:0] bphv;
        logic [AW-1:0] aall;
        bphv = '0;
        bphv[0*DW +: DW] = 48'h10;   bphv[1*DW +: DW] = 48'h20;
        bphv[2*DW +: DW] = 48'h30;   bphv[3*DW +: DW] = 48'hABCD;
        bphv[4*DW +: DW] = 48'h50;   bphv[5*DW +: DW] = 48'h60;
        bphv[6*DW +: DW] = 48'h70;   bphv[7*DW +: DW] = 48'h8000_0000_0001;
        tbl[0] = '{0, {4'b0001, 5'd0, 5'd1, 11'd0},  48'h10,   48'h20};
        tbl[1] = '{2, {4'b0011, 5'd3, 16'h0005},     48'hABCD, 48'h5};
        tbl[2] = '{1, {4'b0010, 5'd9, 5'd7, 11'd0},  48'h0,    48'h8000_0000_0001};
        tbl[3] = '{5, 25'd0,                         48'h60,   48'h0};
        tbl[4] = '{3, {4'b0111, 5'd0, 5'd1, 11'd0},  48'h0,    48'h0};
        tbl[5] = '{7, {4'b1010, 5'd7, 5'd31, 11'd0}, 48'h8000_0000_0001, 48'h0};
        tbl[6] = '{4, {4'b1100, 5'd2, 16'hFFFF},     48'h30,   48'hFFFF};
        tbl[7] = '{6, {4'b0101, 5'd0, 5'd1, 11'd0},  48'h0,    48'h0};
        aall = '0;
        for (int i = 0; i < NA; i++) aall[i*AL +: AL] = {4'b0001, 5'(i), 5'(7 - i), 11'd0};

        #2 rst_n = 1'b0;
        #3 chk_reset_outputs("por");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Decode table: back-to-back bypass pairings
        for (int v = 0; v < 8; v++)
            drive(1'b1, bphv, 1'b1, mk_act(tbl[v].lane, tbl[v].la), tbl[v].lane, tbl[v].e1, tbl[v].e2);
        idle(6);

        // Fill FIFO, hold a 5th PHV while full, then drain in order
        for (int k = 1; k <= 4; k++) drive(1'b1, mkphv(k), 1'b0, '0, -1, '0, '0);
        drive(1'b1, mkphv(5), 1'b0, '0, -1, '0, '0);
        drive(1'b1, mkphv(5), 1'b0, '0, -1, '0, '0);
        drive(1'b1, mkphv(5), 1'b1, aall, -1, '0, '0);
        drive(1'b1, mkphv(5), 1'b1, aall, -1, '0, '0);
        drive(1'b0, '0, 1'b1, aall, -1, '0, '0);
        drive(1'b0, '0, 1'b1, aall, -1, '0, '0);
        drive(1'b0, '0, 1'b1, aall, -1, '0, '0);
        idle(6);

        // Orphan action: dropped, flag sticks
        drive(1'b0, '0, 1'b1, aall, -1, '0, '0);
        idle(5);

        // Reset with 2 PHVs buffered and one pairing in the delay line
        for (int k = 6; k <= 8; k++) drive(1'b1, mkphv(k), 1'b0, '0, -1, '0, '0);
        drive(1'b0, '0, 1'b1, aall, -1, '0, '0);
        idle(1);
        #3 rst_n = 1'b0;
        chk("alu_drained_before_reset", w_t'(alu_sb.size()), w_t'(0));
        phv_sb.delete();
        mq.delete();
        err_m = 1'b0;
        #1 chk_reset_outputs("mid_rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        idle(6);
        drive(1'b1, mkphv(9), 1'b1, aall, -1, '0, '0);
        idle(7);

        chk("alu_sb_empty", w_t'(alu_sb.size()), w_t'(0));
        chk("phv_sb_empty", w_t'(phv_sb.size()), w_t'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/action_operand_xbar.md
# action_operand_xbar

Operand crossbar placed directly upstream of each stage's ALU array. It buffers incoming PHVs until the matching VLIW action arrives from the lookup engine, then decodes each ALU lane's action and selects that lane's two operands from the PHV containers or the action immediate. Per-lane action, valid and operands are registered out to the ALUs. The paired PHV is delayed so it reaches the PHV assembler in the same cycle as the ALU results.

## Interface
- STAGE, 0, stage index, informational only
- ACTION_LEN, 25, bits per lane action
- DATA_WIDTH, 48, container / ALU data width
- NUM_ALU, 8, containers per PHV, equal to ALUs per stage
- PHV_FIFO_DEPTH, 4, PHVs buffered while waiting for an action
- ALU_LATENCY, 3, cycles from ALU action_valid to ALU container_out_valid
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- phv_in  in  NUM_ALU*DATA_WIDTH  PHV; container i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- phv_in_valid  in  1  PHV beat valid
- phv_in_ready  out  1  PHV accepted when valid and ready are both high
- action_in  in  NUM_ALU*ACTION_LEN  VLIW; lane i at bits [i*ACTION_LEN +: ACTION_LEN]
- action_in_valid  in  1  one-cycle pulse per action; no backpressure
- alu_action_out  out  NUM_ALU*ACTION_LEN  per-lane action to the ALUs
- alu_action_valid  out  NUM_ALU  per-lane action valid
- alu_operand_1, alu_operand_2  out  NUM_ALU*DATA_WIDTH  per-lane operands
- phv_aligned_out  out  NUM_ALU*DATA_WIDTH  paired PHV, aligned with ALU outputs
- phv_aligned_valid  out  1  phv_aligned_out valid
- err_orphan_action  out  1  sticky; set when an action is dropped

## Operation
- Lane action fields: opcode [24:21]; op1 index [20:16]; op2 index [15:11]; immediate [15:0]. The op2 index and immediate overlap.
- PHV FIFO:
  - Push when phv_in_valid and phv_in_ready, unless the PHV is bypassed.
  - phv_in_ready = !full, using the registered full flag. A full FIFO refuses a push even in a cycle where it pops.
- Pairing: when action_in_valid is high:
  - FIFO non-empty: pair with the FIFO head and pop it. A PHV arriving in the same cycle is pushed.
  - FIFO empty and phv_in_valid high: bypass. Pair with phv_in directly; the PHV is not written to the FIFO.
  - FIFO empty and no phv_in_valid: drop the action, set err_orphan_action, produce no output.
- Lane i operand selection on a paired cycle:
  - An index value >= NUM_ALU selects 48'h0.
  - 0001, 0010, 1001, 1010: op1 = container[op1 idx]; op2 = container[op2 idx].
  - 0011, 0100, 1011, 1100: op1 = container[op1 idx]; op2 = immediate zero-extended to DATA_WIDTH.
  - 0000 (nop): op1 = container[i]; op2 = 0.
  - Any other opcode: op1 = 0; op2 = 0.
- Lane outputs on a paired cycle:
  - alu_action_valid = all ones.
  - alu_action_out = action_in, unchanged.
- Non-paired cycles: all alu_* outputs are 0.
- err_orphan_action is cleared only by reset.

## Timing
- Pair at edge T: alu_* outputs are valid for exactly one cycle, T+1.
- phv_aligned_valid and phv_aligned_out: valid at T+1+ALU_LATENCY (T+4 by default), the same cycle as the ALU container_out_valid.
- The PHV delay line carries the valid bit with the data. Data is 0 whenever valid is low.
- Throughput: one pairing per cycle, back-to-back.
- FIFO order is strict: actions pair with PHVs in arrival order.
- Reset values: every output is 0 except phv_in_ready, which is 1. The FIFO is empty.
- Reset asserted mid-operation: clears the FIFO, pipeline and delay line immediately. In-flight PHVs are lost; no partial output follows reset release.

## Structure
- Package xbar_pkg:
  - opcode localparams: OP_ADD, OP_SUB, OP_ADDI, OP_SUBI, plus the 1xxx variants and OP_NOP.
  - action field offsets and widths.
  - the IMM_W = 16 constant.
- Sub-module phv_fifo:
  - synchronous, count-based full/empty.
  - width NUM_ALU*DATA_WIDTH, depth PHV_FIFO_DEPTH.
  - pointers wrap modulo depth.
- Top level: pairing logic, per-lane generate-loop mux, output register, ALU_LATENCY-deep shift register.

## Test plan
- Bypass add: phv c0=0x10, c1=0x20; lane 0 action opcode 0001, idx1=0, idx2=1; action and PHV in the same cycle -> at T+1 alu_operand_1[0]=0x10, alu_operand_2[0]=0x20, alu_action_valid=8'hFF; phv_aligned_valid at T+4 with the same PHV.
- Immediate: lane 2 opcode 0011, idx1=3, imm 0x0005, c3=0xABCD -> alu_operand_1[2]=0xABCD, alu_operand_2[2]=0x000000000005.
- Full FIFO: push 4 PHVs with no action -> phv_in_ready low after the 4th; a 5th held valid is not accepted; then 4 actions on consecutive cycles -> outputs pair PHVs 1..4 in order, and ready returns the cycle after the first pop.
- Orphan: action_in_valid with the FIFO empty and no PHV -> no alu_action_valid, err_orphan_action=1 and stays 1.
- Edge decode: idx1=9 with NUM_ALU=8 -> operand 0; lane 5 nop -> alu_operand_1[5]=c5, alu_operand_2[5]=0; opcode 0111 -> both operands 0.
- Reset: assert rst_n low while 2 PHVs are buffered and one pairing is in the delay line -> all outputs 0, phv_in_ready=1; no phv_aligned_valid after release.
